// File: rtl/mc_core_ctrl.sv
// -----------------------------------------------------------------------------
// mc_core_ctrl
// Multi-cycle sequencer for the single-issue RV32I core. It steps each
// instruction through FETCH, DECODE, EXEC, optional MEM and WB around the
// shared decoder, ALU, register file and data-memory port. All outputs are
// registered (Moore) except ir_we, which follows imem_ack in FETCH.
//
// Optional feature (compile-time macro MC_CORE_CTRL_TRAP_EN):
//   defined   - an invalid instruction enters TRAP for one cycle: pc_we=1,
//               pc_sel=11, trap=1, no retire.
//   undefined - TRAP is unreachable and trap stays 0; an invalid instruction
//               retires through WB as a NOP (rf_we=0, pc_sel=00).
//
// Parameters:
//   MEM_TIMEOUT  max MEM cycles waiting for dmem_ack before ERROR (>=1)
//   CNT_W        width of the retired-instruction counter
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   run_en            level; allows new fetches
//   imem_req/ack      instruction fetch handshake; ir_we loads the IR
//   dec_*             decoder control bits, sampled in DECODE
//   br_taken          ALU compare result, sampled in EXEC
//   dmem_req/we/ack   data memory handshake (we=1 for store)
//   rf_we, pc_we      one-cycle register-file / PC write enables
//   pc_sel            00 pc+4, 01 pc+imm, 10 rs1+imm, 11 trap vector
//   retire, instret   retire pulse and wrapping retired-instruction count
//   trap              illegal-instruction pulse
//   err               sticky memory-timeout error
//   state             current state, for debug
// -----------------------------------------------------------------------------
module mc_core_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_we,
    input  logic             dec_valid_inst,
    input  logic             dec_branch,
    input  logic [1:0]       dec_jump,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_reg_write,
    input  logic             br_taken,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic             err,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    // Last MEM cycle index (counter starts at 0 on MEM entry).
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            cur_state;
    logic [WAIT_W-1:0] wait_cnt;

    // Decoder bits captured in DECODE; EXEC/MEM/WB never look at dec_* again.
    logic       lat_branch;
    logic [1:0] lat_jump;
    logic       lat_mem_read;
    logic       lat_mem_write;
    logic       lat_reg_write;
    logic       lat_br_taken;

    logic       br_now;
    logic [1:0] wb_pc_sel;

    // IR load is the only Mealy output: it must coincide with the ack cycle.
    assign ir_we = (cur_state == S_FETCH) && imem_ack;
    assign state = cur_state;

    // PC source for the coming WB. From EXEC the compare result is still on
    // br_taken (it is being latched on the same edge); from MEM use the copy.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        br_now    = (cur_state == S_EXEC) ? br_taken : lat_br_taken;
        wb_pc_sel = 2'b00;
        if (lat_jump == 2'b01) begin
            wb_pc_sel = 2'b01;
        end else if (lat_jump == 2'b11) begin
            wb_pc_sel = 2'b10;
        end else if (lat_branch && br_now) begin
            wb_pc_sel = 2'b01;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state     <= S_IDLE;
            wait_cnt      <= '0;
            lat_branch    <= 1'b0;
            lat_jump      <= 2'b00;
            lat_mem_read  <= 1'b0;
            lat_mem_write <= 1'b0;
            lat_reg_write <= 1'b0;
            lat_br_taken  <= 1'b0;
            imem_req      <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            rf_we         <= 1'b0;
            pc_we         <= 1'b0;
            pc_sel        <= 2'b00;
            retire        <= 1'b0;
            instret       <= '0;
            trap          <= 1'b0;
            err           <= 1'b0;
        end else begin
            // Pulse outputs default low; the state that enters WB/TRAP raises them.
            rf_we  <= 1'b0;
            pc_we  <= 1'b0;
            pc_sel <= 2'b00;
            retire <= 1'b0;
            trap   <= 1'b0;

            unique case (cur_state)
                S_IDLE: begin
                    if (run_en) begin
                        cur_state <= S_FETCH;
                        imem_req  <= 1'b1;
                    end
                end

                // A fetch in flight completes even if run_en drops.
                S_FETCH: begin
                    if (imem_ack) begin
                        cur_state <= S_DECODE;
                        imem_req  <= 1'b0;
                    end
                end

                S_DECODE: begin
                    lat_branch    <= dec_branch;
                    lat_jump      <= dec_jump;
                    lat_mem_read  <= dec_mem_read;
                    lat_mem_write <= dec_mem_write;
                    lat_reg_write <= dec_reg_write;
                    if (!dec_valid_inst) begin
`ifdef MC_CORE_CTRL_TRAP_EN
                        cur_state <= S_TRAP;
                        pc_we     <= 1'b1;
                        pc_sel    <= 2'b11;
                        trap      <= 1'b1;
`else
                        // Retire as a NOP: no register write, fall through to pc+4.
                        cur_state <= S_WB;
                        pc_we     <= 1'b1;
                        retire    <= 1'b1;
                        instret   <= instret + 1'b1;
`endif
                    end else begin
                        cur_state <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    lat_br_taken <= br_taken;
                    if (lat_mem_read || lat_mem_write) begin
                        cur_state <= S_MEM;
                        dmem_req  <= 1'b1;
                        dmem_we   <= lat_mem_write;
                        wait_cnt  <= '0;
                    end else begin
                        cur_state <= S_WB;
                        rf_we     <= lat_reg_write;
                        pc_we     <= 1'b1;
                        pc_sel    <= wb_pc_sel;
                        retire    <= 1'b1;
                        instret   <= instret + 1'b1;
                    end
                end

                // Ack is tested first so an ack in the final allowed cycle wins.
                S_MEM: begin
                    if (dmem_ack) begin
                        cur_state <= S_WB;
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        rf_we     <= lat_reg_write;
                        pc_we     <= 1'b1;
                        pc_sel    <= wb_pc_sel;
                        retire    <= 1'b1;
                        instret   <= instret + 1'b1;
                    end else if (wait_cnt == LAST_WAIT) begin
                        cur_state <= S_ERROR;
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        err       <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_WB, S_TRAP: begin
                    if (run_en) begin
                        cur_state <= S_FETCH;
                        imem_req  <= 1'b1;
                    end else begin
                        cur_state <= S_IDLE;
                    end
                end

                // Sticky: only rst_n leaves ERROR.
                S_ERROR: begin
                    cur_state <= S_ERROR;
                end

                default: begin
                    cur_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
